half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 18 +
 rtl/half_adder_if.sv | 25 ++
 rtl/half_adder_ha_bit.sv | 12 +
 rtl/half_adder.sv | 84 ++++++++
 tb/tb_half_adder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder bank.
// The popcount helper feeds the optional carry counter (HALF_ADDER_POPCOUNT_EN).
package half_adder_pkg;

  localparam int HA_WIDTH_DEFAULT = 8;
  // Widest vector the popcount helper accepts; callers zero-extend narrower ones.
  localparam int HA_POP_MAX = 64;

  function automatic int unsigned popcount(input logic [HA_POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < HA_POP_MAX; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_if.sv
// Registered-result bus of half_adder: capture strobe in, held result plus valid out.
// carry_cnt is present only when HALF_ADDER_POPCOUNT_EN is defined.
// Handshake: in_vld has no ready; a/b are captured on every rising edge where in_vld=1,
// and out_vld is high for exactly the cycle after each capture.
interface half_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_vld;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] cout_q;
  logic             out_vld;
`ifdef HALF_ADDER_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] carry_cnt;
`endif

`ifdef HALF_ADDER_POPCOUNT_EN
  modport master (output in_vld, input sum_q, input cout_q, input out_vld, input carry_cnt);
  modport slave  (input in_vld, output sum_q, output cout_q, output out_vld, output carry_cnt);
`else
  modport master (output in_vld, input sum_q, input cout_q, input out_vld);
  modport slave  (input in_vld, output sum_q, output cout_q, output out_vld);
`endif

endinterface

// File: rtl/half_adder_ha_bit.sv
// Single-bit half adder cell: s = a ^ b, c = a & b.
module ha_bit (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Bank of WIDTH independent half adders with combinational outputs and a 1-cycle registered copy.
// Optional registered carry popcount enabled by HALF_ADDER_POPCOUNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst,
  half_adder_if.slave      bus
);

  // Bits never interact: no carry chain between neighbouring cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ha_bit u_bit (
      .a (a[i]),
      .b (b[i]),
      .s (sum[i]),
      .c (cout[i])
    );
  end

  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [WIDTH-1:0] res_cout_q, res_cout_d;
  logic             vld_q, vld_d;

  always_comb begin
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    vld_d      = 1'b0;
    if (bus.in_vld) begin
      res_sum_d  = sum;
      res_cout_d = cout;
      vld_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_sum_q  <= '0;
      res_cout_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.sum_q   = res_sum_q;
  assign bus.cout_q  = res_cout_q;
  assign bus.out_vld = vld_q;

`ifdef HALF_ADDER_POPCOUNT_EN
  localparam int CW = $clog2(WIDTH+1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [HA_POP_MAX-1:0] cout_ext;

  always_comb begin
    cout_ext             = '0;
    cout_ext[WIDTH-1:0]  = cout;
    cnt_d                = cnt_q;
    if (bus.in_vld) begin
      cnt_d = CW'(popcount(cout_ext));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: combinational vectors, random pairs, and registered path.
// Build with +define+HALF_ADDER_POPCOUNT_EN to also check carry_cnt.
module tb_half_adder;
  import half_adder_pkg::*;

  localparam int W  = HA_WIDTH_DEFAULT;
  localparam int CW = $clog2(W+1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, sum, cout;

  half_adder_if #(.WIDTH(W)) bus ();

  half_adder #(.WIDTH(W)) dut (
    .sum  (sum),
    .cout (cout),
    .a    (a),
    .b    (b),
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {cout, sum} captured at the moment in_vld is driven.
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   hold_sum, hold_cout;
  logic [CW-1:0]  hold_cnt;

  function automatic logic [CW-1:0] ones(input logic [W-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) if (v[i] === 1'b1) n = n + 1'b1;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_vld = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    step();
    step();
    checks++;
    if (bus.sum_q !== '0 || bus.cout_q !== '0 || bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset: sum_q=%h cout_q=%h out_vld=%b, required 00 00 0",
               bus.sum_q, bus.cout_q, bus.out_vld);
    end
`ifdef HALF_ADDER_POPCOUNT_EN
    checks++;
    if (bus.carry_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: carry_cnt=%0d, required 0", bus.carry_cnt);
    end
`endif
    hold_sum  = '0;
    hold_cout = '0;
    hold_cnt  = '0;
  endtask

  task automatic test_comb_vectors();
    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    logic [W-1:0] vs[6];
    logic [W-1:0] vc[6];
    va = '{8'd5, 8'd250, 8'd7, 8'd5,  8'd150, 8'bxz00_1100};
    vb = '{8'd6, 8'd7,   8'd6, 8'd95, 8'd2,   8'b0000_1010};
    vs = '{8'b0000_0011, 8'b1111_1101, 8'b0000_0001, 8'b0101_1010, 8'b1001_0100, 8'bxx00_0110};
    vc = '{8'b0000_0100, 8'b0000_0010, 8'b0000_0110, 8'b0000_0101, 8'b0000_0010, 8'b0000_1000};
    for (int i = 0; i < 6; i++) begin
      a = va[i];
      b = vb[i];
      #1;
      checks++;
      if (sum !== vs[i] || cout !== vc[i]) begin
        errors++;
        $display("FAIL comb_vec%0d: sum=%b cout=%b, required sum=%b cout=%b",
                 i, sum, cout, vs[i], vc[i]);
      end
    end
  endtask

  task automatic test_comb_random();
    logic [W:0] lhs, rhs;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      #1;
      lhs = {1'b0, a} + {1'b0, b};
      rhs = {1'b0, sum} + {cout, 1'b0};
      checks++;
      if (sum !== (a ^ b) || cout !== (a & b) || (sum & cout) !== '0 || lhs !== rhs) begin
        errors++;
        $display("FAIL comb_rand%0d: a=%h b=%h sum=%h cout=%h, required sum=%h cout=%h",
                 i, a, b, sum, cout, a ^ b, a & b);
      end
    end
  endtask

  task automatic test_capture_hold();
    logic [2*W-1:0] e;
    rst = 1'b0;
    bus.in_vld = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    exp_q.push_back({8'hFF, 8'h00});
    hold_sum = 8'h00;
    hold_cout = 8'hFF;
    hold_cnt = CW'(8);
    step();
    checks++;
    if (bus.out_vld !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL capture_vld: out_vld=%b queued=%0d, required 1 and 1", bus.out_vld, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (bus.sum_q !== e[W-1:0] || bus.cout_q !== e[2*W-1:W]) begin
        errors++;
        $display("FAIL capture_data: sum_q=%h cout_q=%h, required %h %h",
                 bus.sum_q, bus.cout_q, e[W-1:0], e[2*W-1:W]);
      end
    end
`ifdef HALF_ADDER_POPCOUNT_EN
    checks++;
    if (bus.carry_cnt !== CW'(8)) begin
      errors++;
      $display("FAIL capture_cnt: carry_cnt=%0d, required 8", bus.carry_cnt);
    end
`endif
    bus.in_vld = 1'b0;
    a = 8'h3C;
    b = 8'h5A;
    step();
    checks++;
    if (bus.out_vld !== 1'b0 || bus.sum_q !== hold_sum || bus.cout_q !== hold_cout) begin
      errors++;
      $display("FAIL hold: out_vld=%b sum_q=%h cout_q=%h, required 0 %h %h",
               bus.out_vld, bus.sum_q, bus.cout_q, hold_sum, hold_cout);
    end
`ifdef HALF_ADDER_POPCOUNT_EN
    checks++;
    if (bus.carry_cnt !== hold_cnt) begin
      errors++;
      $display("FAIL hold_cnt: carry_cnt=%0d, required %0d", bus.carry_cnt, hold_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic           vld;
    logic [2*W-1:0] e;
    for (int i = 0; i < 24; i++) begin
      vld = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_vld = vld;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (vld) begin
        exp_q.push_back({a & b, a ^ b});
        hold_sum  = a ^ b;
        hold_cout = a & b;
        hold_cnt  = ones(a & b);
      end
      step();
      checks++;
      if (bus.out_vld !== vld) begin
        errors++;
        $display("FAIL b2b_vld%0d: out_vld=%b, required %b", i, bus.out_vld, vld);
      end else if (vld) begin
        e = exp_q.pop_front();
        if (bus.sum_q !== e[W-1:0] || bus.cout_q !== e[2*W-1:W]) begin
          errors++;
          $display("FAIL b2b_data%0d: sum_q=%h cout_q=%h, required %h %h",
                   i, bus.sum_q, bus.cout_q, e[W-1:0], e[2*W-1:W]);
        end
      end else if (bus.sum_q !== hold_sum || bus.cout_q !== hold_cout) begin
        errors++;
        $display("FAIL b2b_hold%0d: sum_q=%h cout_q=%h, required %h %h",
                 i, bus.sum_q, bus.cout_q, hold_sum, hold_cout);
      end
`ifdef HALF_ADDER_POPCOUNT_EN
      checks++;
      if (bus.carry_cnt !== hold_cnt) begin
        errors++;
        $display("FAIL b2b_cnt%0d: carry_cnt=%0d, required %0d", i, bus.carry_cnt, hold_cnt);
      end
`endif
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [2*W-1:0] e;
    bus.in_vld = 1'b1;
    a = 8'hA5;
    b = 8'h0F;
    rst = 1'b1;
    step();
    exp_q.delete();
    rst = 1'b0;
    bus.in_vld = 1'b0;
    checks++;
    if (bus.sum_q !== '0 || bus.cout_q !== '0 || bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sum_q=%h cout_q=%h out_vld=%b, required 00 00 0",
               bus.sum_q, bus.cout_q, bus.out_vld);
    end
    step();
    checks++;
    if (bus.sum_q !== '0 || bus.cout_q !== '0 || bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: sum_q=%h cout_q=%h out_vld=%b, required 00 00 0",
               bus.sum_q, bus.cout_q, bus.out_vld);
    end
    bus.in_vld = 1'b1;
    a = 8'hC3;
    b = 8'h81;
    exp_q.push_back({8'h81, 8'h42});
    step();
    bus.in_vld = 1'b0;
    checks++;
    if (bus.out_vld !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL first_after_reset: out_vld=%b queued=%0d, required 1 and 1",
               bus.out_vld, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (bus.sum_q !== e[W-1:0] || bus.cout_q !== e[2*W-1:W]) begin
        errors++;
        $display("FAIL first_after_reset_data: sum_q=%h cout_q=%h, required %h %h",
                 bus.sum_q, bus.cout_q, e[W-1:0], e[2*W-1:W]);
      end
    end
`ifdef HALF_ADDER_POPCOUNT_EN
    checks++;
    if (bus.carry_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL first_after_reset_cnt: carry_cnt=%0d, required 2", bus.carry_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.in_vld = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_comb_vectors();
    test_comb_random();
    test_capture_hold();
    test_back_to_back();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
